// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
//   Requester 0 is the execute stage, requester 1 the branch/address unit.
//   Round-robin arbitration, at most one grant per cycle. The ALU outputs are
//   captured into a per-requester response register on the grant edge.
//
// Ports:
//   clk, reset          clock; synchronous active-low reset
//   req_valid/req_ready per-requester request handshake (req_ready is the grant)
//   req_op*/req_a*/req_b*  request opcode and operands
//   resp_valid/resp_ready  per-requester response handshake
//   resp_result*, resp_flags*  captured result and {equal, lt, ltu}
//   alu_control, A, B   drive the shared ALU (zero when idle)
//   result, equal, less_than, less_than_unsigned  ALU outputs
module alu_arbiter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OPW   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [OPW-1:0]   req_op0,
    input  logic [OPW-1:0]   req_op1,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [WIDTH-1:0] req_b1,
    output logic [1:0]       resp_valid,
    input  logic [1:0]       resp_ready,
    output logic [WIDTH-1:0] resp_result0,
    output logic [WIDTH-1:0] resp_result1,
    output logic [2:0]       resp_flags0,
    output logic [2:0]       resp_flags1,
    output logic [OPW-1:0]   alu_control,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] result,
    input  logic             equal,
    input  logic             less_than,
    input  logic             less_than_unsigned
);

    logic [1:0]       elig;
    logic [1:0]       grant;
    logic             last_grant_q, last_grant_d;
    logic [1:0]       resp_valid_q, resp_valid_d;
    logic [WIDTH-1:0] result0_q, result0_d;
    logic [WIDTH-1:0] result1_q, result1_d;
    logic [2:0]       flags0_q, flags0_d;
    logic [2:0]       flags1_q, flags1_d;
    logic [2:0]       alu_flags;

    assign alu_flags = {equal, less_than, less_than_unsigned};

    // A slot being drained this cycle can take a new result in the same cycle.
    always_comb begin
        elig = 2'b00;
        if (reset) begin
            elig = req_valid & (~resp_valid_q | resp_ready);
        end
        unique case (elig)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            // Contention: favour whichever requester did not win last time.
            2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    assign req_ready = grant;

    always_comb begin
        alu_control = '0;
        A           = '0;
        B           = '0;
        unique case (grant)
            2'b01: begin
                alu_control = req_op0;
                A           = req_a0;
                B           = req_b0;
            end
            2'b10: begin
                alu_control = req_op1;
                A           = req_a1;
                B           = req_b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        resp_valid_d = (resp_valid_q & ~resp_ready) | grant;
        result0_d    = grant[0] ? result    : result0_q;
        flags0_d     = grant[0] ? alu_flags : flags0_q;
        result1_d    = grant[1] ? result    : result1_q;
        flags1_d     = grant[1] ? alu_flags : flags1_q;
        last_grant_d = last_grant_q;
        if (grant[0]) begin
            last_grant_d = 1'b0;
        end else if (grant[1]) begin
            last_grant_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            // last_grant=1 so requester 0 wins the first contended cycle.
            last_grant_q <= 1'b1;
            resp_valid_q <= 2'b00;
            result0_q    <= '0;
            result1_q    <= '0;
            flags0_q     <= 3'b000;
            flags1_q     <= 3'b000;
        end else begin
            last_grant_q <= last_grant_d;
            resp_valid_q <= resp_valid_d;
            result0_q    <= result0_d;
            result1_q    <= result1_d;
            flags0_q     <= flags0_d;
            flags1_q     <= flags1_d;
        end
    end

    assign resp_valid   = resp_valid_q;
    assign resp_result0 = result0_q;
    assign resp_result1 = result1_q;
    assign resp_flags0  = flags0_q;
    assign resp_flags1  = flags1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed stimulus, a behavioural model of the two
// response slots and the round-robin winner, and literal spot checks.
module tb_alu_arbiter;

    localparam logic [3:0] OpAdd  = 4'd0;
    localparam logic [3:0] OpSub  = 4'd1;
    localparam logic [3:0] OpAnd  = 4'd2;
    localparam logic [3:0] OpOr   = 4'd3;
    localparam logic [3:0] OpXor  = 4'd4;
    localparam logic [3:0] OpSlt  = 4'd5;
    localparam logic [3:0] OpSltu = 4'd6;

    logic        clk;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [3:0]  req_op0, req_op1;
    logic [31:0] req_a0, req_a1, req_b0, req_b1;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_ready;
    logic [31:0] resp_result0, resp_result1;
    logic [2:0]  resp_flags0, resp_flags1;
    logic [3:0]  alu_control;
    logic [31:0] alu_a, alu_b;
    logic [31:0] alu_result;
    logic        alu_eq, alu_lt, alu_ltu;

    int n_vec = 0;
    int n_err = 0;

    alu_arbiter #(
        .WIDTH(32),
        .OPW  (4)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_op0           (req_op0),
        .req_op1           (req_op1),
        .req_a0            (req_a0),
        .req_a1            (req_a1),
        .req_b0            (req_b0),
        .req_b1            (req_b1),
        .resp_valid        (resp_valid),
        .resp_ready        (resp_ready),
        .resp_result0      (resp_result0),
        .resp_result1      (resp_result1),
        .resp_flags0       (resp_flags0),
        .resp_flags1       (resp_flags1),
        .alu_control       (alu_control),
        .A                 (alu_a),
        .B                 (alu_b),
        .result            (alu_result),
        .equal             (alu_eq),
        .less_than         (alu_lt),
        .less_than_unsigned(alu_ltu)
    );

    function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [31:0] r;
        case (op)
            OpAdd:   r = a + b;
            OpSub:   r = a - b;
            OpAnd:   r = a & b;
            OpOr:    r = a | b;
            OpXor:   r = a ^ b;
            OpSlt:   r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OpSltu:  r = (a < b) ? 32'd1 : 32'd0;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic logic [2:0] flag_fn(input logic [31:0] a, input logic [31:0] b);
        return {a == b, $signed(a) < $signed(b), a < b};
    endfunction

    // Stand-in for the shared combinational ALU.
    always_comb begin
        logic [2:0] f;
        alu_result = alu_fn(alu_control, alu_a, alu_b);
        f          = flag_fn(alu_a, alu_b);
        alu_eq     = f[2];
        alu_lt     = f[1];
        alu_ltu    = f[0];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model state: what each response slot must hold and who won last.
    bit          m_known = 1'b0;
    logic [1:0]  m_valid;
    logic [31:0] m_res[2];
    logic [2:0]  m_flg[2];
    int          m_last;

    // Compare process: inputs are stable from posedge+1 through the next
    // posedge, so the negedge sees exactly what the coming edge will sample.
    always @(negedge clk) begin : compare
        logic [1:0]  elig;
        int          win;
        logic [3:0]  e_op;
        logic [31:0] e_a, e_b;
        if (!reset) begin
            check("rst_req_ready", 32'(req_ready), 32'd0);
            check("rst_alu_control", 32'(alu_control), 32'd0);
            check("rst_A", alu_a, 32'd0);
            check("rst_B", alu_b, 32'd0);
            m_known  = 1'b1;
            m_valid  = 2'b00;
            m_res[0] = 32'd0;
            m_res[1] = 32'd0;
            m_flg[0] = 3'd0;
            m_flg[1] = 3'd0;
            m_last   = 1;
        end else if (m_known) begin
            for (int i = 0; i < 2; i++) begin
                elig[i] = req_valid[i] && (!m_valid[i] || resp_ready[i]);
            end
            win = -1;
            if (elig == 2'b11)  win = (m_last == 0) ? 1 : 0;
            else if (elig[0])   win = 0;
            else if (elig[1])   win = 1;
            e_op = 4'd0;
            e_a  = 32'd0;
            e_b  = 32'd0;
            if (win == 0) begin
                e_op = req_op0; e_a = req_a0; e_b = req_b0;
            end else if (win == 1) begin
                e_op = req_op1; e_a = req_a1; e_b = req_b1;
            end
            check("req_ready", 32'(req_ready), (win < 0) ? 32'd0 : (32'd1 << win));
            check("alu_control", 32'(alu_control), 32'(e_op));
            check("A", alu_a, e_a);
            check("B", alu_b, e_b);
            check("resp_valid", 32'(resp_valid), 32'(m_valid));
            check("resp_result0", resp_result0, m_res[0]);
            check("resp_result1", resp_result1, m_res[1]);
            check("resp_flags0", 32'(resp_flags0), 32'(m_flg[0]));
            check("resp_flags1", 32'(resp_flags1), 32'(m_flg[1]));
            for (int i = 0; i < 2; i++) begin
                if (win == i) begin
                    m_valid[i] = 1'b1;
                    m_res[i]   = alu_fn(e_op, e_a, e_b);
                    m_flg[i]   = flag_fn(e_a, e_b);
                end else if (resp_ready[i]) begin
                    m_valid[i] = 1'b0;
                end
            end
            if (win >= 0) m_last = win;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b0;
        req_valid  = 2'b00;
        resp_ready = 2'b00;
        req_op0 = OpAdd; req_op1 = OpAdd;
        req_a0 = 32'd0;  req_b0 = 32'd0;
        req_a1 = 32'd0;  req_b1 = 32'd0;

        // Reset then idle.
        tick();
        tick();
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_resp_valid", 32'(resp_valid), 32'd0);
            check("idle_req_ready", 32'(req_ready), 32'd0);
            tick();
        end

        // Single request: 5 + 7.
        req_valid = 2'b01; req_op0 = OpAdd; req_a0 = 32'd5; req_b0 = 32'd7;
        @(negedge clk);
        check("single_req_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        check("single_resp_valid", 32'(resp_valid), 32'd1);
        check("single_result", resp_result0, 32'd12);
        check("single_flags", 32'(resp_flags0), 32'b011);
        resp_ready = 2'b01;
        tick();
        resp_ready = 2'b00;

        // Fresh reset so the contention run starts from last_grant=1.
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        req_valid = 2'b11; resp_ready = 2'b11;
        req_op0 = OpSub; req_a0 = 32'd10; req_b0 = 32'd3;
        req_op1 = OpSub; req_a1 = 32'd3;  req_b1 = 32'd10;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rr_grant", 32'(req_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
            tick();
        end
        @(negedge clk);
        check("rr_result0", resp_result0, 32'd7);
        check("rr_result1", resp_result1, 32'hFFFF_FFF9);
        check("rr_flags0", 32'(resp_flags0), 32'b000);
        check("rr_flags1", 32'(resp_flags1), 32'b011);

        // Back-pressure on requester 0; requester 1 keeps flowing.
        resp_ready = 2'b10;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("bp_req_ready", 32'(req_ready), 32'd2);
            check("bp_hold_result0", resp_result0, 32'd7);
            tick();
        end
        resp_ready = 2'b11;
        @(negedge clk);
        check("bp_release_grant", 32'(req_ready), 32'd1);
        tick();

        // Signed vs unsigned compare.
        req_valid = 2'b01; req_op0 = OpSlt; req_a0 = 32'hFFFF_FFFF; req_b0 = 32'd1;
        @(negedge clk);
        check("slt_req_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        check("slt_result", resp_result0, 32'd1);
        check("slt_flags", 32'(resp_flags0), 32'b010);
        tick();

        // Reset mid-flight right after a grant to requester 0.
        resp_ready = 2'b00;
        req_valid = 2'b01; req_op0 = OpAdd; req_a0 = 32'd1; req_b0 = 32'd2;
        @(negedge clk);
        check("mid_pre_grant", 32'(req_ready), 32'd1);
        tick();
        reset = 1'b0;
        req_valid = 2'b11;
        @(negedge clk);
        check("mid_rst_req_ready", 32'(req_ready), 32'd0);
        tick();
        reset = 1'b1;
        resp_ready = 2'b11;
        @(negedge clk);
        check("mid_cleared", 32'(resp_valid), 32'd0);
        check("mid_first_grant", 32'(req_ready), 32'd1);
        tick();
        req_valid = 2'b00;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
